// File: rtl/secure_keystore_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | secure_keystore_pkg: shared constants, reset key image and FSM states   |
// | for secure_keystore. Optional feature macro: SECURE_KEYSTORE_PARITY_EN  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package secure_keystore_pkg;

  localparam int SECURE_MEMORY_WIDTH  = 256;
  localparam int SECURE_MEMORY_LENGTH = 8;
  localparam int KEY_IDX_W            = $clog2(SECURE_MEMORY_LENGTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ZERO = 1'b1
  } ks_state_e;

  // Entry i holds the byte (0x0F + 0x10*i) replicated across the word.
  localparam logic [SECURE_MEMORY_LENGTH-1:0][SECURE_MEMORY_WIDTH-1:0] KEY_INIT = {
    {32{8'h7F}}, {32{8'h6F}}, {32{8'h5F}}, {32{8'h4F}},
    {32{8'h3F}}, {32{8'h2F}}, {32{8'h1F}}, {32{8'h0F}}
  };

  // Top entry ships locked.
  localparam logic [SECURE_MEMORY_LENGTH-1:0] LOCK_INIT = 8'h80;

endpackage
`default_nettype wire

// File: rtl/secure_keystore.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | secure_keystore: lockable key register array with zeroize sequencer.   |
// | Optional per-entry even parity via SECURE_KEYSTORE_PARITY_EN.          |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module secure_keystore
  import secure_keystore_pkg::*;
#(
  parameter int WIDTH  = SECURE_MEMORY_WIDTH,
  parameter int LENGTH = SECURE_MEMORY_LENGTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [$clog2(LENGTH)-1:0] req_addr,
  input  logic [WIDTH-1:0]          req_wdata,
  input  logic                      req_lock,
  input  logic                      zeroize,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      rd_valid,
  output logic                      err,
  output logic                      busy
);

  localparam int ADDR_W = $clog2(LENGTH);

  // Entries beyond the package image reset to zero / unlocked.
  function automatic logic [WIDTH-1:0] init_entry(input int idx);
    logic [SECURE_MEMORY_WIDTH-1:0] k;
    k = '0;
    if (idx < SECURE_MEMORY_LENGTH) k = KEY_INIT[KEY_IDX_W'(idx)];
    return WIDTH'(k);
  endfunction

  function automatic logic init_lock(input int idx);
    logic l;
    l = 1'b0;
    if (idx < SECURE_MEMORY_LENGTH) l = LOCK_INIT[KEY_IDX_W'(idx)];
    return l;
  endfunction

  ks_state_e          state_q, state_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]   mem_q [LENGTH];
  logic [WIDTH-1:0]   mem_d [LENGTH];
  logic [LENGTH-1:0]  lock_q, lock_d;
  logic [WIDTH-1:0]   rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic               err_q, err_d;
  logic               addr_ok;
`ifdef SECURE_KEYSTORE_PARITY_EN
  logic [LENGTH-1:0]  par_q, par_d;
  logic               par_bad;
`endif

  assign req_ready = (state_q == ST_IDLE) & ~zeroize;
  assign busy      = (state_q == ST_ZERO);
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign err       = err_q;
  assign addr_ok   = 32'(req_addr) < LENGTH;
`ifdef SECURE_KEYSTORE_PARITY_EN
  assign par_bad   = (^mem_q[req_addr]) != par_q[req_addr];
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_d      = mem_q;
    lock_d     = lock_q;
    rd_data_d  = '0;
    rd_valid_d = 1'b0;
    err_d      = 1'b0;
`ifdef SECURE_KEYSTORE_PARITY_EN
    par_d      = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // zeroize wins over a same-cycle request (req_ready is low then)
        if (zeroize) begin
          state_d = ST_ZERO;
          cnt_d   = '0;
        end else if (req_valid) begin
          if (!addr_ok) begin
            err_d = 1'b1;
          end else if (req_we) begin
            if (lock_q[req_addr]) begin
              err_d = 1'b1;
            end else begin
              mem_d[req_addr]  = req_wdata;
              lock_d[req_addr] = req_lock;
`ifdef SECURE_KEYSTORE_PARITY_EN
              par_d[req_addr]  = ^req_wdata;
`endif
            end
          end else begin
            rd_valid_d = 1'b1;
            rd_data_d  = mem_q[req_addr];
`ifdef SECURE_KEYSTORE_PARITY_EN
            if (par_bad) begin
              rd_data_d = '0;
              err_d     = 1'b1;
            end
`endif
          end
        end
      end
      ST_ZERO: begin
        mem_d[cnt_q]  = '0;
        lock_d[cnt_q] = 1'b0;
`ifdef SECURE_KEYSTORE_PARITY_EN
        par_d[cnt_q]  = 1'b0;
`endif
        if (cnt_q == ADDR_W'(LENGTH - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      for (int i = 0; i < LENGTH; i++) begin
        mem_q[ADDR_W'(i)]  <= init_entry(i);
        lock_q[ADDR_W'(i)] <= init_lock(i);
`ifdef SECURE_KEYSTORE_PARITY_EN
        par_q[ADDR_W'(i)]  <= ^init_entry(i);
`endif
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_q      <= mem_d;
      lock_q     <= lock_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
`ifdef SECURE_KEYSTORE_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_secure_keystore.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_secure_keystore: directed scoreboard bench for secure_keystore      |
// | (default 8-entry instance plus a 6-entry instance for range errors).   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_secure_keystore;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_we, req_lock, zeroize;
  logic [2:0]   req_addr;
  logic [255:0] req_wdata;
  logic         req_ready, rd_valid, err, busy;
  logic [255:0] rd_data;

  logic         req_valid_6, req_we_6, req_lock_6, zeroize_6;
  logic [2:0]   req_addr_6;
  logic [255:0] req_wdata_6;
  logic         req_ready_6, rd_valid_6, err_6, busy_6;
  logic [255:0] rd_data_6;

  always #5 clk = ~clk;

  secure_keystore dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_lock(req_lock), .zeroize(zeroize), .rd_data(rd_data),
    .rd_valid(rd_valid), .err(err), .busy(busy)
  );

  secure_keystore #(.WIDTH(256), .LENGTH(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_6), .req_ready(req_ready_6),
    .req_we(req_we_6), .req_addr(req_addr_6), .req_wdata(req_wdata_6),
    .req_lock(req_lock_6), .zeroize(zeroize_6), .rd_data(rd_data_6),
    .rd_valid(rd_valid_6), .err(err_6), .busy(busy_6)
  );

  typedef struct {
    logic         v;
    logic         e;
    logic [255:0] d;
  } exp_t;

  exp_t         sb[$];
  logic [255:0] m_mem [8];
  logic         m_lock [8];
  int           checks = 0;
  int           passes = 0;

  function automatic logic [255:0] kinit(input int i);
    logic [7:0] b;
    b = 8'h0F + 8'(i * 16);
    return {32{b}};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic push(input logic v, input logic e, input logic [255:0] d);
    exp_t x;
    x.v = v; x.e = e; x.d = d;
    sb.push_back(x);
  endtask

  task automatic check_out(input string tag);
    exp_t x;
    x = sb.pop_front();
    chk({tag, ".rd_valid"}, {255'b0, rd_valid}, {255'b0, x.v});
    chk({tag, ".err"},      {255'b0, err},      {255'b0, x.e});
    chk({tag, ".rd_data"},  rd_data,            x.d);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_mem[i]  = kinit(i);
      m_lock[i] = (i == 7);
    end
  endtask

  task automatic do_req(input string tag, input bit we, input logic [2:0] a,
                        input logic [255:0] wd, input bit lk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_lock = lk;
    if (we) begin
      if (m_lock[a]) push(1'b0, 1'b1, '0);
      else begin
        m_mem[a]  = wd;
        m_lock[a] = lk;
        push(1'b0, 1'b0, '0);
      end
    end else begin
      push(1'b1, 1'b0, m_mem[a]);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_out(tag);
  endtask

  task automatic idle(input string tag);
    req_valid = 1'b0;
    push(1'b0, 1'b0, '0);
    @(posedge clk); #1;
    check_out(tag);
  endtask

  task automatic req6(input string tag, input bit we, input logic [2:0] a,
                      input logic ev, input logic ee, input logic [255:0] ed);
    req_valid_6 = 1'b1; req_we_6 = we; req_addr_6 = a; req_wdata_6 = {64{4'h3}};
    @(posedge clk); #1;
    req_valid_6 = 1'b0;
    chk({tag, ".rd_valid"}, {255'b0, rd_valid_6}, {255'b0, ev});
    chk({tag, ".err"},      {255'b0, err_6},      {255'b0, ee});
    chk({tag, ".rd_data"},  rd_data_6,            ed);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    req_valid = 0; req_we = 0; req_lock = 0; zeroize = 0; req_addr = '0; req_wdata = '0;
    req_valid_6 = 0; req_we_6 = 0; req_lock_6 = 0; zeroize_6 = 0; req_addr_6 = '0; req_wdata_6 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.rd_valid",  {255'b0, rd_valid},  '0);
    chk("rst.err",       {255'b0, err},       '0);
    chk("rst.rd_data",   rd_data,             '0);
    chk("rst.busy",      {255'b0, busy},      '0);
    chk("rst.req_ready", {255'b0, req_ready}, 256'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // basic read, then idle zero data, then back-to-back reads
    do_req("rd2", 1'b0, 3'd2, '0, 1'b0);
    idle("idle_after_rd2");
    do_req("rd6", 1'b0, 3'd6, '0, 1'b0);
    do_req("rd7", 1'b0, 3'd7, '0, 1'b0);

    // lock then rejected overwrite
    do_req("wr0_lock", 1'b1, 3'd0, 256'hA5, 1'b1);
    do_req("wr0_locked", 1'b1, 3'd0, 256'h5A, 1'b0);
    do_req("rd0_after_lock", 1'b0, 3'd0, '0, 1'b0);
    do_req("wr7_initlocked", 1'b1, 3'd7, {8{32'hDEADBEEF}}, 1'b0);
    do_req("rd7_kept", 1'b0, 3'd7, '0, 1'b0);
    do_req("wr3", 1'b1, 3'd3, {8{32'h0123_4567}}, 1'b0);
    do_req("rd3", 1'b0, 3'd3, '0, 1'b0);
    do_req("wr3_again", 1'b1, 3'd3, 256'h77, 1'b0);
    do_req("rd3_again", 1'b0, 3'd3, '0, 1'b0);

    // out-of-range address on the 6-entry instance
    req6("l6_rd7", 1'b0, 3'd7, 1'b0, 1'b1, '0);
    req6("l6_wr6", 1'b1, 3'd6, 1'b0, 1'b1, '0);
    req6("l6_rd5", 1'b0, 3'd5, 1'b1, 1'b0, kinit(5));
    req6("l6_rd0", 1'b0, 3'd0, 1'b1, 1'b0, kinit(0));

    // zeroize colliding with a read
    zeroize = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd1;
    #1;
    chk("zero.req_ready", {255'b0, req_ready}, '0);
    push(1'b0, 1'b0, '0);
    @(posedge clk); #1;
    zeroize = 1'b0; req_valid = 1'b0;
    check_out("zero_collide");
    n = 0;
    while (busy && n < 20) begin
      n++;
      if (n == 3) zeroize = 1'b1;
      if (n == 4) begin
        zeroize = 1'b0;
        chk("zero.ready_in_zero", {255'b0, req_ready}, '0);
      end
      @(posedge clk); #1;
    end
    chk("zero.busy_cycles", 256'(n), 256'd8);
    for (int i = 0; i < 8; i++) begin
      m_mem[i] = '0;
      m_lock[i] = 1'b0;
    end
    for (int i = 0; i < 8; i++) do_req("rd_zeroed", 1'b0, 3'(i), '0, 1'b0);
    do_req("wr0_after_zero", 1'b1, 3'd0, 256'hC3C3, 1'b0);
    do_req("rd0_after_zero", 1'b0, 3'd0, '0, 1'b0);

    // reset in the middle of a zeroize sweep
    zeroize = 1'b1;
    @(posedge clk); #1;
    zeroize = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midzero.busy_before", {255'b0, busy}, 256'd1);
    rst_n = 1'b0;
    #1;
    chk("midzero.busy_rst", {255'b0, busy}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    do_req("rd5_after_rst", 1'b0, 3'd5, '0, 1'b0);
    do_req("rd0_after_rst", 1'b0, 3'd0, '0, 1'b0);
    do_req("wr7_after_rst", 1'b1, 3'd7, 256'h1, 1'b0);

`ifdef SECURE_KEYSTORE_PARITY_EN
    begin
      logic pb;
      pb = ^kinit(4);
      force dut.par_q[4] = ~pb;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd4;
      push(1'b1, 1'b1, '0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      check_out("parity_bad");
      release dut.par_q[4];
    end
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
